// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: keeps the F, D and X slots of a three-stage front end,
// follows branch predictions at fetch and redirects on an EXEC mispredict.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        f_predict_valid,
  input  logic [31:0] f_predict_addr,
  input  logic        x_branch_valid,
  input  logic        x_branch_taken,
  input  logic [31:0] x_target_addr,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic [31:0] d_pc,
  output logic        d_valid,
  output logic        x_predict_res,
  output logic        x_redirect
);

  logic [31:0] f_pc_q, f_pc_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic        d_pred_q, d_pred_d;
  logic [31:0] d_pred_addr_q, d_pred_addr_d;
  logic [31:0] x_pc_q, x_pc_d;
  logic        x_valid_q, x_valid_d;
  logic        x_pred_q, x_pred_d;
  logic [31:0] x_pred_addr_q, x_pred_addr_d;

  logic        pred_taken;
  logic        resolve;
  logic [31:0] x_seq_pc;
  logic [31:0] actual_pc;
  logic [31:0] predicted_pc;
  logic        mispredict;

  // Branch resolution in X; a branch report against an empty X slot is ignored.
  always_comb begin
    pred_taken   = f_valid_q & f_predict_valid;
    resolve      = x_branch_valid & x_valid_q;
    x_seq_pc     = x_pc_q + PC_STEP;
    actual_pc    = x_branch_taken ? x_target_addr : x_seq_pc;
    predicted_pc = x_pred_q ? x_pred_addr_q : x_seq_pc;
    mispredict   = resolve & (actual_pc != predicted_pc);
  end

  assign x_redirect    = mispredict;
  assign x_predict_res = resolve & ~mispredict;

  // Next-state selection: redirect beats everything, then fetch start-up, stall, prediction.
  always_comb begin
    f_pc_d        = f_pc_q;
    f_valid_d     = f_valid_q;
    d_pc_d        = d_pc_q;
    d_valid_d     = d_valid_q;
    d_pred_d      = d_pred_q;
    d_pred_addr_d = d_pred_addr_q;
    x_pc_d        = x_pc_q;
    x_valid_d     = x_valid_q;
    x_pred_d      = x_pred_q;
    x_pred_addr_d = x_pred_addr_q;

    if (mispredict) begin
      // Restart fetch at the resolved address and kill the younger slots.
      f_pc_d    = actual_pc;
      f_valid_d = 1'b1;
      d_valid_d = 1'b0;
      x_valid_d = 1'b0;
    end else begin
      if (!f_valid_q) begin
        // First fetch after reset reuses the current PC.
        f_valid_d = 1'b1;
      end else if (!stall) begin
        f_pc_d = pred_taken ? f_predict_addr : (f_pc_q + PC_STEP);
      end

      if (stall) begin
        // F and D hold; X drains into a bubble.
        x_valid_d = 1'b0;
      end else begin
        d_pc_d        = f_pc_q;
        d_valid_d     = f_valid_q;
        d_pred_d      = pred_taken;
        d_pred_addr_d = f_predict_addr;
        x_pc_d        = d_pc_q;
        x_valid_d     = d_valid_q;
        x_pred_d      = d_pred_q;
        x_pred_addr_d = d_pred_addr_q;
      end
    end
  end

  // Slot registers; reset clears all in-flight state immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_q        <= RESET_PC;
      f_valid_q     <= 1'b0;
      d_pc_q        <= 32'h0;
      d_valid_q     <= 1'b0;
      d_pred_q      <= 1'b0;
      d_pred_addr_q <= 32'h0;
      x_pc_q        <= 32'h0;
      x_valid_q     <= 1'b0;
      x_pred_q      <= 1'b0;
      x_pred_addr_q <= 32'h0;
    end else begin
      f_pc_q        <= f_pc_d;
      f_valid_q     <= f_valid_d;
      d_pc_q        <= d_pc_d;
      d_valid_q     <= d_valid_d;
      d_pred_q      <= d_pred_d;
      d_pred_addr_q <= d_pred_addr_d;
      x_pc_q        <= x_pc_d;
      x_valid_q     <= x_valid_d;
      x_pred_q      <= x_pred_d;
      x_pred_addr_q <= x_pred_addr_d;
    end
  end

  assign f_pc    = f_pc_q;
  assign f_valid = f_valid_q;
  assign d_pc    = d_pc_q;
  assign d_valid = d_valid_q;

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: f_pc value at reset.
REQ-002 Parameter PC_STEP, default 32'd1: sequential increment; the PC is word-addressed.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  downstream hazard: hold the F and D stages.
REQ-006 f_predict_valid  input  1  predictor hit for the current f_pc.
REQ-007 f_predict_addr  input  32  predicted target for the current f_pc.
REQ-008 x_branch_valid  input  1  EXEC resolved a branch this cycle.
REQ-009 x_branch_taken  input  1  resolved direction.
REQ-010 x_target_addr  input  32  resolved taken target.
REQ-011 f_pc  output  32  fetch PC, fed to the predictor.
REQ-012 f_valid  output  1  f_pc is a live fetch.
REQ-013 d_pc  output  32  decode-stage PC, fed to the predictor.
REQ-014 d_valid  output  1  decode slot live.
REQ-015 x_predict_res  output  1  prediction-correct pulse, fed to the predictor.
REQ-016 x_redirect  output  1  mispredict pulse; younger stages are flushed.

Function
REQ-017 Three tracked slots SHALL be kept:
- F: f_pc, f_valid.
- D: d_pc, d_valid, d_pred, d_pred_addr.
- X: x_pc, x_valid, x_pred, x_pred_addr.
REQ-018 pred_taken = f_valid & f_predict_valid.
REQ-019 Next-PC priority, highest first:
- redirect;
- f_valid=0 (hold the PC, set f_valid);
- stall (hold);
- pred_taken (f_predict_addr);
- otherwise f_pc + PC_STEP.
REQ-020 All PC arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32 (32'hFFFF_FFFF + 1 = 0).
REQ-021 Advance (no stall, no redirect): D <= {f_pc, f_valid, pred_taken, f_predict_addr}; X <= D.
REQ-022 Stall without redirect:
- F and D hold;
- X <= bubble (x_valid=0).
REQ-023 Resolution applies only when x_branch_valid & x_valid; x_branch_valid with x_valid=0 is ignored (both pulses stay 0).
REQ-024 During resolution:
- actual = x_branch_taken ? x_target_addr : x_pc + PC_STEP;
- predicted = x_pred ? x_pred_addr : x_pc + PC_STEP.
REQ-025 Resolution with actual == predicted SHALL assert x_predict_res combinationally in that same cycle, with no other effect.
REQ-026 Resolution with actual != predicted SHALL assert x_redirect combinationally in that cycle, and at the next edge:
- f_pc <= actual;
- f_valid <= 1;
- d_valid <= 0;
- x_valid <= 0.
REQ-027 Redirect SHALL override a simultaneous stall and a simultaneous pred_taken.
REQ-028 x_predict_res and x_redirect SHALL be mutually exclusive and SHALL be 0 whenever x_valid = 0.
REQ-029 Latency:
- a taken prediction changes f_pc one cycle after f_predict_valid is sampled;
- a redirect reaches f_pc one cycle after x_redirect is asserted.
REQ-030 d_pc SHALL reflect the D slot even when d_valid = 0; consumers qualify it with d_valid.

Reset
REQ-031 While rst_n = 0, asynchronously:
- f_pc = RESET_PC and f_valid = 0;
- d_pc = 0, d_valid = 0, d_pred = 0, d_pred_addr = 0;
- x_pc = 0, x_valid = 0, x_pred = 0, x_pred_addr = 0;
- x_predict_res = 0 and x_redirect = 0.
REQ-032 First edge after deassertion: f_valid <= 1 and f_pc holds RESET_PC; sequential advance starts at the following edge.
REQ-033 Reset asserted mid-operation, including during stall or redirect, SHALL discard all in-flight state immediately.

Verification
REQ-034 Sequential run: reset, no predictions, no stall -> f_pc = 0,0,1,2,3; d_pc lags f_pc by one cycle.
REQ-035 Correct prediction: f_pc=5 with f_predict_valid=1, addr=32'h40; two cycles later x_branch_valid=1, taken=1, target=32'h40 -> f_pc=32'h40 the cycle after f_pc=5; x_predict_res=1 one cycle; x_redirect=0.
REQ-036 Mispredict, not-taken predicted: f_pc=8 not predicted; resolved taken to 32'h100 -> x_redirect=1; next f_pc=32'h100; d_valid=0.
REQ-037 Mispredict, taken predicted: f_pc=8 predicted to 32'h20; resolved not-taken -> x_redirect=1; next f_pc=9; younger slots flushed.
REQ-038 Stall and redirect collide: stall=1 in the same cycle as a mispredict to 32'h80 -> f_pc=32'h80 next cycle. Separately, stall=1 alone for 3 cycles -> f_pc and d_pc hold and x_valid=0.
REQ-039 Wrap and reset: f_pc=32'hFFFF_FFFF, no prediction -> next f_pc=0. rst_n pulsed low for 1 ns mid-run -> f_pc=RESET_PC and both pulses 0 immediately.
